mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single memory-controller port between the CPU instruction-fetch requester and the load/store requester. Each requester uses a req/ack handshake. The arbiter latches the winning request and drives it onto one downstream bus. Data accesses have priority, with a streak limit so fetch cannot starve, and a per-access timeout. It sits between the pipeline front end / memory stage and `memory_controller` when the core moves to a multi-cycle memory.

## Interface
Parameters:
- `MAX_DATA_STREAK`, default 4: maximum number of consecutive data grants while a fetch is pending. Must be ≥1.
- `TIMEOUT_CYCLES`, default 16: bus cycles to wait for `i_bus_ack` before aborting. 0 disables the timeout.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_inst_req` in 1, `i_inst_addr` in 32: fetch request. Read-only, always 32-bit.
- `o_inst_ack` out 1, `o_inst_rdata` out 32: fetch completion.
- `i_data_req` in 1, `i_data_addr` in 32, `i_data_wdata` in 32, `i_data_width` in 2, `i_data_we` in 1, `i_data_zeroextend` in 1: load/store request.
- `o_data_ack` out 1, `o_data_rdata` out 32: load/store completion.
- `o_bus_req` out 1, `o_bus_addr` out 32, `o_bus_wdata` out 32, `o_bus_width` out 2, `o_bus_we` out 1, `o_bus_zeroextend` out 1: downstream bus request.
- `i_bus_ack` in 1, `i_bus_rdata` in 32: downstream completion. `i_bus_ack` is a one-cycle pulse.
- `o_timeout` out 1: one-cycle pulse when an access is aborted.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- **Grant decision.** Evaluated in IDLE, and in BUSY_* on the cycle the access completes (ack or timeout).
  - Candidates are the raised requests. The requester being completed this cycle is excluded.
  - Data wins unless `streak == MAX_DATA_STREAK` and a fetch request is present; in that case fetch wins.
  - No candidate → next state is IDLE.
- **Streak counter.** Width `$clog2(MAX_DATA_STREAK+1)`.
  - +1 on each data grant, saturating.
  - Cleared on a fetch grant.
  - Cleared in any IDLE cycle with no fetch request.
- **Grant latching.** On grant, the winning requester's payload is latched into bus registers. Fetch grants force `we=0`, `width=2'b10`, `zeroextend=0`.
  - `o_bus_*` are driven only from these registers.
  - `o_bus_req` = state is BUSY_I or BUSY_D.
- **Completion.** In BUSY_X with `i_bus_ack`:
  - `o_X_ack=1` combinationally.
  - `o_X_rdata = i_bus_rdata`. The other requester's rdata is 0 whenever its ack is low.
- **Requester rules.**
  - Hold req and payload stable until ack.
  - Deassert req the cycle after ack, or immediately raise the next request.
  - Payload changes while req is high and unacked are undefined.
- **Timeout.**
  - A wait counter clears on grant and increments each BUSY cycle without ack.
  - When it reaches `TIMEOUT_CYCLES-1` without ack: `o_X_ack=1`, `o_X_rdata=0`, `o_timeout=1`, and the bus access is abandoned.
  - Ack and timeout in the same cycle: ack wins, `o_timeout=0`, real rdata.
- **Reset.** Synchronous; takes priority over everything, including mid-access.
  - State → IDLE; streak, wait counter and bus registers → 0.
  - `i_bus_ack` during reset is ignored: no requester ack.
- **Reset values of outputs:** all 0.

## Timing
- Request raised in cycle N while IDLE → `o_bus_req`, with latched payload, high in N+1.
- Bus ack in cycle M → requester ack in M (zero added latency on the return path). Minimum access = 2 cycles from req to ack.
- Back-to-back: a re-grant in the ack cycle gives `o_bus_req` continuously high. Peak throughput is 1 access/cycle with a zero-wait bus.
- Simultaneous fetch and data requests in IDLE: data granted first. Fetch granted on data's ack cycle, since data is excluded then.
- Worst-case fetch wait: `MAX_DATA_STREAK` data accesses.

## Structure
- Shared package `mem_pkg`:
  - `arb_state_t` enum.
  - Width encodings: `WIDTH_B=0`, `WIDTH_H=1`, `WIDTH_W=2`.
  - Fetch defaults.
  - A `mem_req_t` struct (addr, wdata, width, we, zeroextend), used for both requester payloads and the latched bus register.
- Single module; no sub-module. Streak and wait counters are inline.

## Test plan
- Fetch only, bus acks 1 cycle after `o_bus_req`, addr `0x10000000`:
  - `o_bus_req` in N+1, `o_inst_ack` in N+2, rdata = `i_bus_rdata`.
  - `o_bus_we=0`, `o_bus_width=2`.
- Fetch + store raised together (data addr `0x20000004`, wdata `0xCAFEF00D`, we=1), zero-wait bus:
  - Data granted first, fetch on the next cycle.
  - `o_bus_req` high 2 consecutive cycles.
- Data req held high continuously, fetch pending, `MAX_DATA_STREAK=4`:
  - Exactly 4 data grants, then 1 fetch grant, then data resumes.
- Bus never acks, `TIMEOUT_CYCLES=16`, data load:
  - `o_data_ack=1`, rdata=0, `o_timeout=1` on BUSY cycle 16.
  - Arbiter returns to IDLE.
- Ack and timeout in the same cycle → normal ack, `o_timeout=0`.
- `i_rst` asserted mid-BUSY_D with `i_bus_ack=1` in the same cycle:
  - No `o_data_ack`.
  - Next cycle all outputs 0, state IDLE, streak 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: FSM states, access widths and
// the request payload carried from requesters to the memory-controller bus.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] WIDTH_B = 2'd0;
  localparam logic [1:0] WIDTH_H = 2'd1;
  localparam logic [1:0] WIDTH_W = 2'd2;

  localparam logic FETCH_WE         = 1'b0;
  localparam logic FETCH_ZEROEXTEND = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        we;
    logic        zeroextend;
  } mem_req_t;

  // Instruction fetches are always full-word reads.
  function automatic mem_req_t fetch_req(input logic [31:0] addr);
    mem_req_t r;
    r            = '0;
    r.addr       = addr;
    r.width      = WIDTH_W;
    r.we         = FETCH_WE;
    r.zeroextend = FETCH_ZEROEXTEND;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requesters onto one memory bus.
// Data has priority, bounded by a streak limit; each access has a timeout.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inst_req,
  input  logic [31:0] i_inst_addr,
  output logic        o_inst_ack,
  output logic [31:0] o_inst_rdata,
  input  logic        i_data_req,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic [1:0]  i_data_width,
  input  logic        i_data_we,
  input  logic        i_data_zeroextend,
  output logic        o_data_ack,
  output logic [31:0] o_data_rdata,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [1:0]  o_bus_width,
  output logic        o_bus_we,
  output logic        o_bus_zeroextend,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_timeout
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
  localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  mem_req_t            bus_q, bus_d;

  logic     busy, ack_hit, timed_out, done;
  logic     inst_done, data_done, inst_cand, data_cand;
  logic     eval, grant_i, grant_d;
  mem_req_t data_payload;

  always_comb begin
    busy      = (state_q != IDLE);
    ack_hit   = busy && i_bus_ack && !i_rst;
    timed_out = TIMEOUT_EN && busy && !i_bus_ack && !i_rst && (wait_q == WAIT_LAST);
    done      = ack_hit || timed_out;
    inst_done = done && (state_q == BUSY_I);
    data_done = done && (state_q == BUSY_D);
    // The requester finishing this cycle cannot win the next slot.
    inst_cand = i_inst_req && !inst_done;
    data_cand = i_data_req && !data_done;
    eval      = (state_q == IDLE) || done;
    grant_d   = eval && data_cand && !(inst_cand && (streak_q == STREAK_MAX));
    grant_i   = eval && inst_cand && !grant_d;

    data_payload            = '0;
    data_payload.addr       = i_data_addr;
    data_payload.wdata      = i_data_wdata;
    data_payload.width      = i_data_width;
    data_payload.we         = i_data_we;
    data_payload.zeroextend = i_data_zeroextend;
  end

  // A data grant counts toward the streak even on an otherwise-clearing idle cycle.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    wait_d   = wait_q;
    bus_d    = bus_q;
    if (grant_d) begin
      state_d  = BUSY_D;
      bus_d    = data_payload;
      wait_d   = '0;
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
    end else if (grant_i) begin
      state_d  = BUSY_I;
      bus_d    = fetch_req(i_inst_addr);
      wait_d   = '0;
      streak_d = '0;
    end else if (done) begin
      state_d = IDLE;
      wait_d  = '0;
    end else if (busy) begin
      wait_d = wait_q + 1'b1;
    end else if (!i_inst_req) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      wait_q   <= '0;
      bus_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      wait_q   <= wait_d;
      bus_q    <= bus_d;
    end
  end

  always_comb begin
    o_bus_req        = busy;
    o_bus_addr       = bus_q.addr;
    o_bus_wdata      = bus_q.wdata;
    o_bus_width      = bus_q.width;
    o_bus_we         = bus_q.we;
    o_bus_zeroextend = bus_q.zeroextend;
    o_inst_ack       = inst_done;
    o_data_ack       = data_done;
    o_inst_rdata     = (inst_done && ack_hit) ? i_bus_rdata : '0;
    o_data_rdata     = (data_done && ack_hit) ? i_bus_rdata : '0;
    o_timeout        = timed_out;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_mem_arbiter;

  localparam int MAXS = 4;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic        o_inst_ack;
  logic [31:0] o_inst_rdata;
  logic        i_data_req;
  logic [31:0] i_data_addr, i_data_wdata;
  logic [1:0]  i_data_width;
  logic        i_data_we, i_data_zeroextend;
  logic        o_data_ack;
  logic [31:0] o_data_rdata;
  logic        o_bus_req;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [1:0]  o_bus_width;
  logic        o_bus_we, o_bus_zeroextend;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;
  logic        o_timeout;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr),
    .o_inst_ack(o_inst_ack), .o_inst_rdata(o_inst_rdata),
    .i_data_req(i_data_req), .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
    .i_data_width(i_data_width), .i_data_we(i_data_we), .i_data_zeroextend(i_data_zeroextend),
    .o_data_ack(o_data_ack), .o_data_rdata(o_data_rdata),
    .o_bus_req(o_bus_req), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .o_bus_width(o_bus_width), .o_bus_we(o_bus_we), .o_bus_zeroextend(o_bus_zeroextend),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .o_timeout(o_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who owns the bus (0 none, 1 fetch, 2 data), busy cycles waited,
  // consecutive data grants, and the payload presented on the bus.
  int          m_owner = 0, m_wait = 0, m_streak = 0, ack_delay = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [1:0]  m_width = '0;
  logic        m_we = 1'b0, m_zx = 1'b0, m_done;
  logic        e_iack, e_dack, e_to;
  logic [31:0] e_irdata, e_drdata;
  logic        prev_iack = 1'b0, prev_dack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_eval();
    logic acked, timed;
    acked = (m_owner != 0) && i_bus_ack && !i_rst;
    timed = (m_owner != 0) && !i_bus_ack && !i_rst && (m_wait == TO - 1);
    m_done   = acked || timed;
    e_iack   = (m_owner == 1) && m_done;
    e_dack   = (m_owner == 2) && m_done;
    e_irdata = ((m_owner == 1) && acked) ? i_bus_rdata : 32'h0;
    e_drdata = ((m_owner == 2) && acked) ? i_bus_rdata : 32'h0;
    e_to     = timed;
  endtask

  task automatic pick_delay();
    int r;
    r = int'($urandom % 10);
    if (r < 5)      ack_delay = 0;
    else if (r < 7) ack_delay = 1 + int'($urandom % 3);
    else if (r < 9) ack_delay = int'($urandom % 15);
    else            ack_delay = 15 + int'($urandom % 3);
  endtask

  task automatic model_next();
    logic ic, dc;
    if (i_rst) begin
      m_owner = 0; m_wait = 0; m_streak = 0;
      m_addr = '0; m_wdata = '0; m_width = '0; m_we = 1'b0; m_zx = 1'b0;
    end else if (m_owner == 0 || m_done) begin
      ic = i_inst_req && !(m_owner == 1 && m_done);
      dc = i_data_req && !(m_owner == 2 && m_done);
      if (dc && !(ic && m_streak == MAXS)) begin
        m_addr = i_data_addr; m_wdata = i_data_wdata; m_width = i_data_width;
        m_we = i_data_we; m_zx = i_data_zeroextend;
        m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        m_owner = 2; m_wait = 0; pick_delay();
      end else if (ic) begin
        m_addr = i_inst_addr; m_wdata = '0; m_width = 2'd2; m_we = 1'b0; m_zx = 1'b0;
        m_streak = 0; m_owner = 1; m_wait = 0; pick_delay();
      end else begin
        if (m_owner == 0 && !i_inst_req) m_streak = 0;
        m_owner = 0; m_wait = 0;
      end
    end else begin
      m_wait++;
    end
  endtask

  task automatic check_model();
    model_eval();
    chk("bus_req", o_bus_req, m_owner != 0);
    chk("bus_addr", o_bus_addr, m_addr);
    chk("bus_wdata", o_bus_wdata, m_wdata);
    chk("bus_width", o_bus_width, m_width);
    chk("bus_we", o_bus_we, m_we);
    chk("bus_zx", o_bus_zeroextend, m_zx);
    chk("inst_ack", o_inst_ack, e_iack);
    chk("inst_rdata", o_inst_rdata, e_irdata);
    chk("data_ack", o_data_ack, e_dack);
    chk("data_rdata", o_data_rdata, e_drdata);
    chk("timeout", o_timeout, e_to);
  endtask

  task automatic cyc();
    #1;
    check_model();
    prev_iack = e_iack;
    prev_dack = e_dack;
    model_next();
    @(negedge clk);
  endtask

  task automatic set_data(input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] w, input logic we);
    i_data_req = 1'b1; i_data_addr = a; i_data_wdata = wd;
    i_data_width = w; i_data_we = we; i_data_zeroextend = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_inst_req = 1'b0; i_inst_addr = '0;
    i_data_req = 1'b0; i_data_addr = '0; i_data_wdata = '0; i_data_width = '0;
    i_data_we = 1'b0; i_data_zeroextend = 1'b0; i_bus_ack = 1'b0; i_bus_rdata = '0;
    @(negedge clk);
    cyc();
    i_rst = 1'b0;
    #1;
    chk("reset_bus_req", o_bus_req, 1'b0);
    chk("reset_bus_addr", o_bus_addr, 32'h0);
    cyc();

    // Fetch only, bus acks one cycle after o_bus_req.
    i_inst_req = 1'b1; i_inst_addr = 32'h1000_0000;
    #1; chk("f_req_n", o_bus_req, 1'b0);
    cyc();
    #1; chk("f_req_n1", o_bus_req, 1'b1);
    chk("f_addr", o_bus_addr, 32'h1000_0000);
    chk("f_we", o_bus_we, 1'b0);
    chk("f_width", o_bus_width, 2'd2);
    cyc();
    i_bus_ack = 1'b1; i_bus_rdata = 32'h1357_2468;
    #1; chk("f_ack_n2", o_inst_ack, 1'b1);
    chk("f_rdata", o_inst_rdata, 32'h1357_2468);
    chk("f_no_dack", o_data_ack, 1'b0);
    cyc();
    i_inst_req = 1'b0; i_bus_ack = 1'b0;
    #1; chk("f_idle", o_bus_req, 1'b0);
    cyc();

    // Fetch and store together on a zero-wait bus.
    i_inst_req = 1'b1; i_inst_addr = 32'h1000_0040;
    set_data(32'h2000_0004, 32'hCAFE_F00D, 2'd2, 1'b1);
    cyc();
    i_bus_ack = 1'b1; i_bus_rdata = 32'h0;
    #1; chk("fs_req1", o_bus_req, 1'b1);
    chk("fs_daddr", o_bus_addr, 32'h2000_0004);
    chk("fs_dwdata", o_bus_wdata, 32'hCAFE_F00D);
    chk("fs_dwe", o_bus_we, 1'b1);
    chk("fs_dack", o_data_ack, 1'b1);
    cyc();
    i_data_req = 1'b0; i_bus_rdata = 32'h0BAD_F00D;
    #1; chk("fs_req2", o_bus_req, 1'b1);
    chk("fs_iaddr", o_bus_addr, 32'h1000_0040);
    chk("fs_iack", o_inst_ack, 1'b1);
    chk("fs_irdata", o_inst_rdata, 32'h0BAD_F00D);
    cyc();
    i_inst_req = 1'b0; i_bus_ack = 1'b0;
    #1; chk("fs_idle", o_bus_req, 1'b0);
    cyc();

    // Four data grants build the streak; a fetch then wins over pending data.
    set_data(32'h2000_0100, 32'h0, 2'd2, 1'b0);
    for (int g = 0; g < 4; g++) begin
      i_bus_ack = 1'b0; cyc();
      i_bus_ack = 1'b1; i_bus_rdata = 32'h100 + 32'(g);
      #1; chk("st_dack", o_data_ack, 1'b1);
      cyc();
    end
    i_bus_ack = 1'b0; i_inst_req = 1'b1; i_inst_addr = 32'h1000_0080;
    cyc();
    i_bus_ack = 1'b1;
    #1; chk("st_fetch_wins", o_bus_addr, 32'h1000_0080);
    chk("st_iack", o_inst_ack, 1'b1);
    cyc();
    i_inst_req = 1'b0;
    #1; chk("st_data_resumes", o_bus_addr, 32'h2000_0100);
    cyc();
    i_data_req = 1'b0; i_bus_ack = 1'b0;
    cyc();

    // Bus never acks: timeout on busy cycle 16.
    set_data(32'h2000_0010, 32'h0, 2'd2, 1'b0);
    i_bus_rdata = 32'hDEAD_BEEF;
    cyc();
    for (int k = 1; k <= 16; k++) begin
      #1;
      if (k == 15) begin
        chk("to_early_ack", o_data_ack, 1'b0);
        chk("to_early_flag", o_timeout, 1'b0);
      end
      if (k == 16) begin
        chk("to_ack", o_data_ack, 1'b1);
        chk("to_rdata", o_data_rdata, 32'h0);
        chk("to_flag", o_timeout, 1'b1);
      end
      cyc();
    end
    i_data_req = 1'b0;
    #1; chk("to_idle", o_bus_req, 1'b0);
    cyc();

    // Ack coinciding with the timeout cycle is a normal completion.
    set_data(32'h2000_0020, 32'h0, 2'd1, 1'b0);
    cyc();
    for (int k = 1; k <= 16; k++) begin
      i_bus_ack = (k == 16);
      i_bus_rdata = 32'h0BAD_CAFE;
      #1;
      if (k == 16) begin
        chk("at_ack", o_data_ack, 1'b1);
        chk("at_flag", o_timeout, 1'b0);
        chk("at_rdata", o_data_rdata, 32'h0BAD_CAFE);
      end
      cyc();
    end
    i_data_req = 1'b0; i_bus_ack = 1'b0;
    cyc();

    // Reset mid-access swallows a simultaneous bus ack.
    set_data(32'h2000_0030, 32'h1234_5678, 2'd0, 1'b1);
    cyc();
    i_rst = 1'b1; i_bus_ack = 1'b1;
    #1; chk("rst_no_dack", o_data_ack, 1'b0);
    chk("rst_no_rdata", o_data_rdata, 32'h0);
    cyc();
    i_rst = 1'b0; i_bus_ack = 1'b0; i_data_req = 1'b0;
    #1; chk("rst_bus_req", o_bus_req, 1'b0);
    chk("rst_bus_addr", o_bus_addr, 32'h0);
    chk("rst_bus_wdata", o_bus_wdata, 32'h0);
    chk("rst_bus_we", o_bus_we, 1'b0);
    cyc();

    // Randomized traffic obeying the requester handshake rules.
    for (int c = 0; c < 3000; c++) begin
      i_rst = ($urandom % 200) == 0;
      if (!i_inst_req || prev_iack) begin
        i_inst_req  = ($urandom % 3) != 0;
        i_inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!i_data_req || prev_dack) begin
        i_data_req        = ($urandom % 3) != 0;
        i_data_addr       = $urandom;
        i_data_wdata      = $urandom;
        i_data_width      = 2'($urandom % 3);
        i_data_we         = 1'($urandom);
        i_data_zeroextend = 1'($urandom);
      end
      i_bus_ack   = (m_owner != 0) && (m_wait == ack_delay);
      i_bus_rdata = $urandom;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
